module_planificador_tx: RTL and testbench
=========================================

# module_planificador_tx

Controller that shares the single Hamming(7,4) encoder between two 4-bit requesters and transmits each resulting 7-bit codeword as a serial frame. It sits between the input sources (switch bank / test generator) and the encoder instance. It arbitrates round-robin, drives the encoder's 4-bit input from a holding register, and captures the encoder's 7-bit output. It then shifts the codeword out on a single line with start and stop bits.

## Interface
Parameters:
- BIT_DIV, default 4: clock cycles per serial bit; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_a_valid  in  1  requester A has a word.
- req_a_datos  in  4  requester A data word; must be held stable while req_a_valid=1 and req_a_ready=0.
- req_a_ready  out  1  A word accepted this cycle; combinational.
- req_b_valid  in  1  requester B has a word.
- req_b_datos  in  4  requester B data word; same stability rule as A.
- req_b_ready  out  1  B word accepted this cycle; combinational.
- cod_datos_in  out  4  registered word driven to the encoder's 4-bit input.
- cod_datos_cod  in  7  encoder's 7-bit codeword output; combinational function of cod_datos_in.
- tx_serial  out  1  registered serial line; idles high.
- tx_ocupado  out  1  high whenever state is not IDLE.
- tx_origen  out  1  source of the current or last frame: 0 = A, 1 = B.

## Operation
- FSM states: IDLE, CARGA, START, DATOS, STOP.
- Handshake:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - ready is asserted only in IDLE, only for the granted requester, and only while rst=0.
- Arbitration in IDLE:
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester selected by pointer `prio` is granted.
  - After every grant, prio is set to the other requester.
  - prio does not change when no grant occurs.
  - Reset value of prio is A.
- IDLE → CARGA on a grant. In the same edge: cod_datos_in ← granted datos; tx_origen ← granted source.
- CARGA (exactly 1 cycle): shift register ← cod_datos_cod; bit counter ← 0; divider ← 0. → START.
- START: tx_serial=0 for BIT_DIV cycles. → DATOS.
- DATOS:
  - Sends codeword bits 0..6, LSB first (parity bit c0 first).
  - Each bit is held BIT_DIV cycles.
  - After bit 6 completes → STOP.
- STOP: tx_serial=1 for BIT_DIV cycles. → IDLE.
- Divider: counts 0..BIT_DIV-1 and wraps. Bit counter is 3 bits and counts 0..6.
- cod_datos_in holds its value until the next grant; it is not cleared at end of frame.
- Requests arriving while not IDLE are ignored; the requester keeps valid asserted.
- Reset while rst=1:
  - state=IDLE, tx_serial=1, tx_ocupado=0, tx_origen=0, cod_datos_in=0, prio=A, counters=0, shift register=0.
  - Both ready outputs are forced to 0.
  - Assertion mid-frame aborts the frame. tx_serial returns high on the next edge and no partial frame resumes.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: CARGA. tx_ocupado=1 from cycle 1.
- Cycle 2: start bit begins on tx_serial.
- Data bit k occupies cycles 2+(k+1)·BIT_DIV through 2+(k+2)·BIT_DIV−1.
- Stop bit occupies cycles 2+8·BIT_DIV through 2+9·BIT_DIV−1.
- Cycle 2+9·BIT_DIV: back in IDLE; the next handshake may occur in that same cycle.
- Minimum spacing between accepted words: 2+9·BIT_DIV cycles.
- Frame on the line: 0, c[0], c[1], …, c[6], 1, with the codeword bit order given by cod_datos_cod[0..6].

## Test plan
All scenarios use a real encoder instance connected to cod_datos_in / cod_datos_cod.
- BIT_DIV=1; A sends 4'b1011, B idle.
  - req_a_ready=1 at cycle 0; cod_datos_in=4'b1011 from cycle 1; cod_datos_cod=7'b1010101.
  - tx_serial over cycles 2..10 = 0,1,0,1,0,1,0,1,1; tx_origen=0; tx_ocupado=1 for cycles 1..10; IDLE at cycle 11.
- BIT_DIV=4; B sends 4'b1111.
  - Codeword 7'b1111111; tx_serial low for cycles 2..5, then high for cycles 6..37.
  - tx_ocupado falls at cycle 38.
- Both requesters valid continuously: A=4'b0000, B=4'b1111, BIT_DIV=1.
  - Grants alternate A, B, A, … starting with A after reset; one grant every 11 cycles.
  - tx_origen toggles per frame; frame data 0,0000000,1 then 0,1111111,1.
- Word held during busy: B raises valid at cycle 3 of an A frame.
  - req_b_ready stays 0 until cycle 11; B is accepted at cycle 11 and its start bit appears at cycle 13.
- Reset mid-frame: rst=1 at cycle 5 of a BIT_DIV=1 frame.
  - Next edge: tx_serial=1, tx_ocupado=0, tx_origen=0, cod_datos_in=0, prio=A.
  - After rst drops, a new A request is accepted immediately and a full 9-bit frame follows.
- Ready gating: valid asserted while rst=1 → req_a_ready=0 and req_b_ready=0, and no grant occurs.

Source files
------------

// File: rtl/module_planificador_tx.sv
// Transmit scheduler: round-robin arbitration of two 4-bit requesters onto one
// shared Hamming(7,4) encoder, followed by start/7-data/stop serialisation.

module hamming_cod_7_4 (
    input  logic [3:0] datos,
    output logic [6:0] codigo
);

    // Codeword layout c[0..6] = p1, p2, d0, p3, d1, d2, d3 with even parity
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    // Purely combinational encoder
    always_comb begin
        codigo = hamming_encode(datos);
    end

endmodule

module module_planificador_tx_chk (
    input logic clk,
    input logic rst,
    input logic req_a_ready,
    input logic req_b_ready,
    input logic tx_serial,
    input logic tx_ocupado
);

    a_ready_exclusive: assert property (@(posedge clk) !(req_a_ready && req_b_ready));

    a_ready_only_idle: assert property (@(posedge clk)
        (req_a_ready || req_b_ready) |-> (!tx_ocupado && !rst));

    a_idle_line_high: assert property (@(posedge clk) disable iff (rst)
        !tx_ocupado |-> tx_serial);

endmodule

module module_planificador_tx #(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a_valid,
    input  logic [3:0] req_a_datos,
    output logic       req_a_ready,
    input  logic       req_b_valid,
    input  logic [3:0] req_b_datos,
    output logic       req_b_ready,
    output logic [3:0] cod_datos_in,
    input  logic [6:0] cod_datos_cod,
    output logic       tx_serial,
    output logic       tx_ocupado,
    output logic       tx_origen
);

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CARGA = 3'd1,
        START = 3'd2,
        DATOS = 3'd3,
        STOP  = 3'd4
    } estado_t;

    estado_t    state_r;
    estado_t    state_next_s;
    logic       prio_r;
    logic       prio_next_s;
    logic [3:0] cod_datos_in_r;
    logic [3:0] cod_datos_in_next_s;
    logic       tx_origen_r;
    logic       tx_origen_next_s;
    logic       tx_serial_r;
    logic       tx_serial_next_s;
    logic       tx_ocupado_r;
    logic [6:0] shift_r;
    logic [6:0] shift_next_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_next_s;
    logic [7:0] div_r;
    logic [7:0] div_next_s;
    logic       grant_s;
    logic       grant_b_s;
    logic       div_end_s;

    assign div_end_s = (div_r == DIV_LAST);

    // Arbiter: a lone requester wins; on contention prio picks (0 = A, 1 = B)
    always_comb begin
        grant_s   = 1'b0;
        grant_b_s = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if (req_a_valid && req_b_valid) begin
                grant_s   = 1'b1;
                grant_b_s = prio_r;
            end else if (req_a_valid) begin
                grant_s   = 1'b1;
                grant_b_s = 1'b0;
            end else if (req_b_valid) begin
                grant_s   = 1'b1;
                grant_b_s = 1'b1;
            end else begin
                grant_s   = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_s   = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Ready is the grant itself so the handshake completes in the same cycle
    always_comb begin
        req_a_ready = grant_s & ~grant_b_s;
        req_b_ready = grant_s & grant_b_s;
    end

    // Next-state and datapath; tx_serial is computed one cycle ahead so the
    // registered line lines up with the state it belongs to
    always_comb begin
        state_next_s        = state_r;
        prio_next_s         = prio_r;
        cod_datos_in_next_s = cod_datos_in_r;
        tx_origen_next_s    = tx_origen_r;
        tx_serial_next_s    = tx_serial_r;
        shift_next_s        = shift_r;
        bit_cnt_next_s      = bit_cnt_r;
        div_next_s          = div_r;
        case (state_r)
            IDLE: begin
                tx_serial_next_s = 1'b1;
                if (grant_s) begin
                    state_next_s        = CARGA;
                    prio_next_s         = ~grant_b_s;
                    cod_datos_in_next_s = grant_b_s ? req_b_datos : req_a_datos;
                    tx_origen_next_s    = grant_b_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CARGA: begin
                shift_next_s     = cod_datos_cod;
                bit_cnt_next_s   = 3'd0;
                div_next_s       = 8'd0;
                tx_serial_next_s = 1'b0;
                state_next_s     = START;
            end
            START: begin
                if (div_end_s) begin
                    div_next_s       = 8'd0;
                    tx_serial_next_s = shift_r[0];
                    state_next_s     = DATOS;
                end else begin
                    div_next_s = div_r + 8'd1;
                end
            end
            DATOS: begin
                if (div_end_s) begin
                    div_next_s = 8'd0;
                    if (bit_cnt_r == LAST_BIT) begin
                        tx_serial_next_s = 1'b1;
                        state_next_s     = STOP;
                    end else begin
                        bit_cnt_next_s   = bit_cnt_r + 3'd1;
                        shift_next_s     = {1'b0, shift_r[6:1]};
                        tx_serial_next_s = shift_r[1];
                    end
                end else begin
                    div_next_s = div_r + 8'd1;
                end
            end
            STOP: begin
                tx_serial_next_s = 1'b1;
                if (div_end_s) begin
                    div_next_s   = 8'd0;
                    state_next_s = IDLE;
                end else begin
                    div_next_s = div_r + 8'd1;
                end
            end
            default: begin
                state_next_s     = IDLE;
                tx_serial_next_s = 1'b1;
                div_next_s       = 8'd0;
                bit_cnt_next_s   = 3'd0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            prio_r         <= 1'b0;
            cod_datos_in_r <= 4'd0;
            tx_origen_r    <= 1'b0;
            tx_serial_r    <= 1'b1;
            tx_ocupado_r   <= 1'b0;
            shift_r        <= 7'd0;
            bit_cnt_r      <= 3'd0;
            div_r          <= 8'd0;
        end else begin
            state_r        <= state_next_s;
            prio_r         <= prio_next_s;
            cod_datos_in_r <= cod_datos_in_next_s;
            tx_origen_r    <= tx_origen_next_s;
            tx_serial_r    <= tx_serial_next_s;
            tx_ocupado_r   <= (state_next_s != IDLE);
            shift_r        <= shift_next_s;
            bit_cnt_r      <= bit_cnt_next_s;
            div_r          <= div_next_s;
        end
    end

    assign cod_datos_in = cod_datos_in_r;
    assign tx_origen    = tx_origen_r;
    assign tx_serial    = tx_serial_r;
    assign tx_ocupado   = tx_ocupado_r;

    module_planificador_tx_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .req_a_ready (req_a_ready),
        .req_b_ready (req_b_ready),
        .tx_serial   (tx_serial),
        .tx_ocupado  (tx_ocupado)
    );

endmodule

// File: tb/tb_module_planificador_tx.sv
// Scoreboard bench with two lanes (BIT_DIV=1 and BIT_DIV=4), each pairing the
// scheduler with a real encoder, a reference model, drivers and a line monitor.

module tb_module_planificador_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       org;
        logic [3:0] dat;
        logic [6:0] cw;
        int         start_cyc;
    } frame_t;

    task automatic check(input string name, input int lane, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane%0d cycle %0d: got %0d, expected %0d", name, lane, cyc, act, exp);
        end
    endtask

    // Hamming(7,4) from first principles: data at positions 3,5,6,7; parity at
    // position p covers every data position whose index has bit p set
    function automatic logic [6:0] ref_code(input logic [3:0] d);
        int         data_pos[4] = '{3, 5, 6, 7};
        logic [7:1] word;
        logic       par;
        word = '0;
        for (int i = 0; i < 4; i++) word[data_pos[i]] = d[i];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int i = 0; i < 4; i++)
                if ((data_pos[i] & p) != 0) par = par ^ d[i];
            word[p] = par;
        end
        return word;
    endfunction

    genvar g;
    for (g = 0; g < 2; g++) begin : g_lane
        localparam int BD   = (g == 0) ? 1 : 4;
        localparam int FLEN = 2 + 9 * BD;

        logic       rst;
        logic       a_v, b_v;
        logic [3:0] a_d, b_d;
        logic       a_rdy, b_rdy, ser, ocu, org;
        logic [3:0] cin;
        logic [6:0] ccod;

        logic [3:0]  qa[$];
        logic [3:0]  qb[$];
        int unsigned gap_max = 0;
        int          gap_a = 0, gap_b = 0;
        logic        done = 1'b0;

        frame_t     exp_q[$];
        int         pos = 0;
        logic       prio_m = 1'b0;
        logic [3:0] cin_m = 4'd0;
        logic       org_m = 1'b0;
        logic       rst_prev = 1'b0;
        logic       fire_a = 1'b0, fire_b = 1'b0;

        logic   mon_on = 1'b0;
        int     mon_cnt = 0;
        frame_t cur;

        hamming_cod_7_4 u_enc (.datos(cin), .codigo(ccod));

        module_planificador_tx #(.BIT_DIV(BD)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .req_a_valid   (a_v),
            .req_a_datos   (a_d),
            .req_a_ready   (a_rdy),
            .req_b_valid   (b_v),
            .req_b_datos   (b_d),
            .req_b_ready   (b_rdy),
            .cod_datos_in  (cin),
            .cod_datos_cod (ccod),
            .tx_serial     (ser),
            .tx_ocupado    (ocu),
            .tx_origen     (org)
        );

        // Reference model: busy for FLEN cycles after each grant, alternating priority
        always @(negedge clk) begin : model
            logic   ga, gb;
            frame_t f;
            ga = 1'b0;
            gb = 1'b0;
            if (!rst && pos == 0) begin
                if (a_v && b_v) begin
                    ga = !prio_m;
                    gb = prio_m;
                end else begin
                    ga = a_v;
                    gb = b_v;
                end
            end
            check("ready_a", g, int'(a_rdy), int'(ga));
            check("ready_b", g, int'(b_rdy), int'(gb));
            check("ocupado", g, int'(ocu), int'(pos != 0));
            check("cod_datos_in", g, int'(cin), int'(cin_m));
            check("origen", g, int'(org), int'(org_m));
            if (rst_prev) check("serial_after_reset", g, int'(ser), 1);
            fire_a   = ga;
            fire_b   = gb;
            rst_prev = rst;
            if (rst) begin
                pos    = 0;
                prio_m = 1'b0;
                cin_m  = 4'd0;
                org_m  = 1'b0;
                exp_q.delete();
            end else if (ga || gb) begin
                pos         = 1;
                prio_m      = ga;
                cin_m       = gb ? b_d : a_d;
                org_m       = gb;
                f.org       = gb;
                f.dat       = cin_m;
                f.cw        = ref_code(cin_m);
                f.start_cyc = cyc + 2;
                exp_q.push_back(f);
            end else if (pos != 0) begin
                pos = (pos == FLEN - 1) ? 0 : pos + 1;
            end
        end

        // Line monitor: on a start bit pop the expected frame and check every cycle of it
        always @(negedge clk) begin : monitor
            int   idx;
            logic eb;
            if (rst) begin
                mon_on = 1'b0;
            end else begin
                if (!mon_on && ser == 1'b0) begin
                    check("frame_expected", g, int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("start_cycle", g, cyc, cur.start_cyc);
                        check("frame_origen", g, int'(org), int'(cur.org));
                        check("frame_cod_in", g, int'(cin), int'(cur.dat));
                        mon_on  = 1'b1;
                        mon_cnt = 0;
                    end
                end
                if (mon_on) begin
                    idx = mon_cnt / BD;
                    if (idx == 0) eb = 1'b0;
                    else if (idx == 8) eb = 1'b1;
                    else eb = cur.cw[idx-1];
                    check("serial_bit", g, int'(ser), int'(eb));
                    mon_cnt++;
                    if (mon_cnt == 9 * BD) mon_on = 1'b0;
                end
            end
        end

        // One clock of stimulus: retire accepted words and present queued ones
        task automatic tick();
            @(posedge clk);
            #1;
            if (fire_a) begin
                a_v   = 1'b0;
                gap_a = int'($urandom_range(gap_max, 0));
            end
            if (!a_v) begin
                if (gap_a > 0) gap_a--;
                else if (qa.size() > 0) begin
                    a_d = qa.pop_front();
                    a_v = 1'b1;
                end
            end
            if (fire_b) begin
                b_v   = 1'b0;
                gap_b = int'($urandom_range(gap_max, 0));
            end
            if (!b_v) begin
                if (gap_b > 0) gap_b--;
                else if (qb.size() > 0) begin
                    b_d = qb.pop_front();
                    b_v = 1'b1;
                end
            end
        endtask

        function automatic logic lane_idle();
            return qa.size() == 0 && qb.size() == 0 && !a_v && !b_v &&
                   pos == 0 && exp_q.size() == 0 && !mon_on;
        endfunction

        task automatic wait_idle(input int budget, input string tag);
            int n;
            n = 0;
            while (!lane_idle() && n < budget) begin
                tick();
                n++;
            end
            check(tag, g, int'(lane_idle()), 1);
        endtask

        initial begin : seq
            rst = 1'b1;
            a_v = 1'b0;
            b_v = 1'b0;
            a_d = 4'd0;
            b_d = 4'd0;
            // Both valid during reset: no grant; then A=0000/B=1111 alternate from A
            for (int i = 0; i < 3; i++) begin
                qa.push_back(4'b0000);
                qb.push_back(4'b1111);
            end
            repeat (4) tick();
            rst = 1'b0;
            wait_idle(10 * FLEN, "drain_alternate");
            qa.push_back(4'b1011);
            wait_idle(3 * FLEN, "drain_a_only");
            qb.push_back(4'b1111);
            wait_idle(3 * FLEN, "drain_b_only");
            // B arrives while an A frame is on the line
            qa.push_back(4'b1011);
            repeat (3) tick();
            qb.push_back(4'b0110);
            wait_idle(4 * FLEN, "drain_held_b");
            // Reset mid-frame, then both request: prio must be back at A
            qa.push_back(4'b1001);
            for (int i = 0; i < 4 * FLEN && pos != 5; i++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            qa.push_back(4'b0011);
            qb.push_back(4'b1100);
            wait_idle(4 * FLEN, "drain_after_reset");
            // Random words with random gaps
            gap_max = 3;
            for (int i = 0; i < 25; i++) begin
                qa.push_back(4'($urandom));
                qb.push_back(4'($urandom));
            end
            wait_idle(100 * FLEN, "drain_random");
            done = 1'b1;
        end
    end

    initial begin : main
        int n;
        n = 0;
        while (!(g_lane[0].done && g_lane[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("lanes_done", 0, int'(g_lane[0].done && g_lane[1].done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
